mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit, 8:1-selected datapath among eight requesters.
- Each requester presents a word and a request. The arbiter picks one winner per transfer, drives the 3-bit select, and captures the selected word into a registered output.
- The output uses a valid/ready handshake to the downstream consumer.
- The winner receives a one-cycle acknowledge.

Parameters:
- WIDTH, 32, data width of each input word and of out.
- N_REQ, 8, number of requesters; fixed at 8 (select is 3 bits). Other values are unsupported.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  8  req[i]=1: requester i has a valid word on in_i
- in0..in7  input  32 each  requester data words
- out_ready  input  1  consumer accepts out this cycle when out_valid=1
- out  output  32  registered captured word
- out_valid  output  1  out holds a word not yet accepted
- select  output  3  index of the requester whose word is in out
- ack  output  8  one-hot pulse; ack[i]=1 for exactly one cycle after requester i's word is captured
- busy  output  1  equals out_valid

Behaviour:
- Reset (async, active-high, takes effect immediately):
  - out=0, out_valid=0, select=0, ack=0.
  - Internal pointer ptr=7, so requester 0 has first priority after reset.
  - State IDLE.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1; out and select are stable.
- Capture opportunity: any cycle in IDLE, or any cycle in HOLD with out_ready=1 (the current word is consumed).
- Eligibility mask: elig = req & ~ack. A requester whose ack is high this cycle is ineligible, so its stale request is never recaptured.
- Winner: the first set bit of elig searching ptr+1, ptr+2, ... wrapping mod 8. The search is combinational.
- On a capture opportunity with elig≠0, at the clock edge:
  - out<=in[winner], select<=winner, out_valid<=1.
  - ack<=onehot(winner), ptr<=winner, state<=HOLD.
- On a capture opportunity with elig=0:
  - out_valid<=0 and state<=IDLE.
  - out and select keep their last values; they are don't-care for the consumer.
- In HOLD with out_ready=0: out, select, out_valid and ptr hold. No new capture; ack<=0.
- ack is 0 in every cycle other than the single cycle following a capture.
- Requester protocol: hold req and in_i stable until ack[i] is seen. On ack, either drop req or present the next word.
- Latency:
  - From req rising in IDLE to out_valid=1 with the word on out: 1 cycle.
  - ack rises in the same cycle as out_valid.
- Throughput:
  - With out_ready held at 1 and several requesters active: one word per cycle.
  - A lone requester is served every other cycle because of the ack mask.
- Fairness: after requester k is served, k has the lowest priority at the next capture. With all requests asserted, service order is strictly k+1, k+2, ... mod 8.
- out_ready while out_valid=0 is ignored.
- Mid-operation reset discards any held word and pending ack. No ack is issued afterwards for that word.

Optional Feature:
Macro MUX8_ARB_PRIO0_EN.
- Defined: requester 0 is a fixed high-priority port. If elig[0]=1 at a capture opportunity, requester 0 wins regardless of ptr, and ptr<=0. Otherwise the round-robin search proceeds as normal.
- Undefined: pure round robin as described above; no priority logic is synthesized.

Test Plan:
- Reset check: assert reset mid-run with out_valid=1 -> immediately out=0, out_valid=0, ack=0, select=0. First capture after release with req=8'hFF selects 0.
- Single request: req=8'b0000_1000, in3=32'hDEADBEEF, out_ready=1 -> next cycle out=32'hDEADBEEF, select=3, ack=8'h08 for one cycle, out_valid=1.
- Full round robin: req=8'hFF, in_i=i, out_ready=1, requesters keep req high -> select sequence 0,1,2,...,7,0, one per cycle; ack walks one-hot.
- Backpressure: capture in5=32'h5 with out_ready=0 for 4 cycles and req=8'hFF -> out=5, select=5 stable, ack=0 after the first cycle. On out_ready=1, the next capture is requester 6.
- Lone back-to-back: req=8'h01 held, in0 increments on each ack, out_ready=1 -> out_valid alternates 1,0,1,0 and each captured value appears once.
- Macro MUX8_ARB_PRIO0_EN defined: req=8'hFF with out_ready=1 -> select stays 0 on every capture opportunity where elig[0]=1. With req=8'hFE, order is 1,2,...,7,1.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one registered 8:1 datapath among eight requesters.
// Optional macro MUX8_ARB_PRIO0_EN makes requester 0 a fixed high-priority port.
module mux8_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [2:0]       select,
  output logic [N_REQ-1:0] ack,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] words [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [2:0]       ptr;
  logic [2:0]       winner;
  logic             cap_opp;
  logic             capture;

  assign words[0] = in0;
  assign words[1] = in1;
  assign words[2] = in2;
  assign words[3] = in3;
  assign words[4] = in4;
  assign words[5] = in5;
  assign words[6] = in6;
  assign words[7] = in7;

  // A requester acked this cycle still shows its old request; mask it out.
  assign elig    = req & ~ack;
  assign cap_opp = (state == IDLE) | out_ready;

  // Scan from lowest to highest priority so the nearest set bit after ptr wins last.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] e, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = p + 3'(k);
      if (e[idx]) rr_pick = idx;
    end
  endfunction

`ifdef MUX8_ARB_PRIO0_EN
  assign winner = elig[0] ? 3'd0 : rr_pick(elig, ptr);
`else
  assign winner = rr_pick(elig, ptr);
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (cap_opp) begin
      if (|elig) begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Capture stage: word, select, pointer and the one-cycle acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out    <= '0;
      select <= '0;
      ack    <= '0;
      ptr    <= 3'd7;
    end else begin
      ack <= '0;
      if (capture) begin
        out    <= words[winner];
        select <= winner;
        ack    <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
        ptr    <= winner;
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = out_valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed vector table, hand sequences, and random
// traffic compared against a behavioural model of the arbitration rules.
module tb_mux8_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [31:0] din [8];
  logic        out_ready;
  logic [31:0] out;
  logic        out_valid;
  logic [2:0]  select;
  logic [7:0]  ack;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_out;
  logic [2:0]  m_sel;
  logic [7:0]  m_ack;
  int          m_ptr;

  mux8_rr_arbiter #(.WIDTH(32), .N_REQ(8)) dut (
    .clock(clock), .reset(reset), .req(req),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .out_ready(out_ready), .out(out), .out_valid(out_valid),
    .select(select), .ack(ack), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_out   = '0;
    m_sel   = '0;
    m_ack   = '0;
    m_ptr   = 7;
  endtask

  // Next state from the rules: capture when idle or consumed, nearest eligible after ptr.
  task automatic model_step();
    bit         opp;
    logic [7:0] el;
    int         w;
    opp = !m_valid || out_ready;
    el  = req & ~m_ack;
    w   = -1;
    if (opp && el != 8'h00) begin
`ifdef MUX8_ARB_PRIO0_EN
      if (el[0]) w = 0;
`endif
      for (int k = 1; k <= 8 && w < 0; k++)
        if (el[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      m_out   = din[w];
      m_sel   = 3'(w);
      m_valid = 1'b1;
      m_ack   = 8'h01 << w;
      m_ptr   = w;
    end else begin
      m_ack = 8'h00;
      if (opp) m_valid = 1'b0;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst.out", out, 32'h0);
    chk("rst.valid", 32'(out_valid), 32'h0);
    chk("rst.ack", 32'(ack), 32'h0);
    chk("rst.select", 32'(select), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".busy"}, 32'(busy), 32'(m_valid));
    chk({tag, ".ack"}, 32'(ack), 32'(m_ack));
    chk({tag, ".select"}, 32'(select), 32'(m_sel));
    chk({tag, ".out"}, out, m_out);
  endtask

  typedef struct {
    bit          rst;
    logic [7:0]  rq;
    bit          rdy;
    bit          v;
    logic [2:0]  s;
    logic [7:0]  a;
    logic [31:0] o;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [31:0] exp_word;

    reset = 1'b1; req = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = 32'(i);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

`ifndef MUX8_ARB_PRIO0_EN
    // Full round robin, then backpressure on requester 5, then lone requester 0.
    tbl[0] = '{1, 8'hFF, 1, 1, 3'd0, 8'h01, 32'd0};
    for (int i = 1; i < 8; i++) tbl[i] = '{0, 8'hFF, 1, 1, 3'(i), 8'h01 << i, 32'(i)};
    tbl[8]  = '{0, 8'hFF, 1, 1, 3'd0, 8'h01, 32'd0};
    tbl[9]  = '{1, 8'h20, 0, 1, 3'd5, 8'h20, 32'd5};
    for (int i = 10; i < 14; i++) tbl[i] = '{0, 8'hFF, 0, 1, 3'd5, 8'h00, 32'd5};
    tbl[14] = '{0, 8'hFF, 1, 1, 3'd6, 8'h40, 32'd6};
    tbl[15] = '{0, 8'hFF, 1, 1, 3'd7, 8'h80, 32'd7};
    tbl[16] = '{0, 8'h00, 1, 0, 3'd7, 8'h00, 32'd0};
    tbl[17] = '{0, 8'h00, 1, 0, 3'd7, 8'h00, 32'd0};
    tbl[18] = '{0, 8'h01, 1, 1, 3'd0, 8'h01, 32'd0};
    tbl[19] = '{0, 8'h01, 1, 0, 3'd0, 8'h00, 32'd0};
    tbl[20] = '{0, 8'h01, 1, 1, 3'd0, 8'h01, 32'd0};
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].rst) do_reset();
      req = tbl[i].rq;
      out_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d.select", i), 32'(select), 32'(tbl[i].s));
      chk($sformatf("vec%0d.ack", i), 32'(ack), 32'(tbl[i].a));
      if (tbl[i].v) chk($sformatf("vec%0d.out", i), out, tbl[i].o);
    end
`else
    // Fixed-priority port 0 absent: plain rotation over requesters 1..7.
    do_reset();
    req = 8'hFE; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("prio.sel%0d", i), 32'(select), 32'((i % 7) + 1));
    end
    req = 8'hFF;
    cyc();
    chk("prio.port0", 32'(select), 32'd0);
`endif

    // Single request
    do_reset();
    din[3] = 32'hDEADBEEF;
    req = 8'b0000_1000; out_ready = 1'b1;
    cyc();
    chk("single.out", out, 32'hDEADBEEF);
    chk("single.select", 32'(select), 32'd3);
    chk("single.ack", 32'(ack), 32'h08);
    chk("single.valid", 32'(out_valid), 32'd1);
    req = 8'h00;
    cyc();
    chk("single.ack_drop", 32'(ack), 32'h00);
    chk("single.valid_drop", 32'(out_valid), 32'd0);
    din[3] = 32'd3;

    // Lone requester presenting a new word on each ack
    do_reset();
    din[0] = 32'd100; exp_word = 32'd100;
    req = 8'h01; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k % 2 == 0) begin
        chk($sformatf("lone%0d.valid", k), 32'(out_valid), 32'd1);
        chk($sformatf("lone%0d.out", k), out, exp_word);
        chk($sformatf("lone%0d.ack", k), 32'(ack), 32'h01);
        din[0] = din[0] + 32'd1;
        exp_word = exp_word + 32'd1;
      end else begin
        chk($sformatf("lone%0d.valid", k), 32'(out_valid), 32'd0);
        chk($sformatf("lone%0d.ack", k), 32'(ack), 32'h00);
      end
    end
    din[0] = 32'd0;

    // Reset asserted mid-cycle while a word is held and unacknowledged
    do_reset();
    req = 8'h20; out_ready = 1'b0;
    cyc();
    chk("midrst.ack_pre", 32'(ack), 32'h20);
    cyc();
    chk("midrst.valid_pre", 32'(out_valid), 32'd1);
    #2;
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    cyc();
    chk("midrst.first_sel", 32'(select), 32'd0);
    chk("midrst.first_ack", 32'(ack), 32'h01);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req = 8'($urandom);
      if (n % 50 < 10) req = 8'hFF;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) din[i] = $urandom;
      cyc();
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
